sine_phase_sequencer: RTL

// - Dual-channel phase-accumulator sequencer that drives both address ports of the dual-port sine ROM.
// - Generates addr1 from a phase accumulator and addr2 = addr1 + programmable phase offset.

---
 rtl/sine_phase_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sine_phase_sequencer.sv
// Dual-channel phase-accumulator address sequencer for a dual-port sine ROM.
// Optional burst mode (period counter, burst_len/done ports) is enabled by defining SINE_BURST_EN.
module sine_phase_sequencer #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int PHASE_WIDTH   = 16,
    parameter int BURST_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [PHASE_WIDTH-1:0]   cfg_incr,
    input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
    output logic [ADDRESS_WIDTH-1:0] addr1,
    output logic [ADDRESS_WIDTH-1:0] addr2,
    output logic                     dout_valid,
    output logic                     wrap,
`ifdef SINE_BURST_EN
    output logic                     busy,
    input  logic [BURST_WIDTH-1:0]   burst_len,
    output logic                     done
`else
    output logic                     busy
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [PHASE_WIDTH-1:0]   RESET_INCR   = PHASE_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] RESET_OFFSET = ADDRESS_WIDTH'(1) << (ADDRESS_WIDTH - 2);

    generate
        if (PHASE_WIDTH < ADDRESS_WIDTH || ADDRESS_WIDTH < 2 || BURST_WIDTH < 1) begin : g_param_check
            $error("sine_phase_sequencer: illegal parameter combination");
        end
    endgenerate

    state_t                     state_q, state_d;
    logic [PHASE_WIDTH-1:0]     phase_q, phase_d;
    logic [PHASE_WIDTH-1:0]     incr_q, incr_d;
    logic [ADDRESS_WIDTH-1:0]   offset_q, offset_d;
    logic [PHASE_WIDTH-1:0]     shadow_incr_q, shadow_incr_d;
    logic [ADDRESS_WIDTH-1:0]   shadow_offset_q, shadow_offset_d;
    logic                       dout_valid_q, dout_valid_d;
    logic                       wrap_q, wrap_d;
    logic [PHASE_WIDTH:0]       sum;
    logic                       accept;
    logic                       run_end;
`ifdef SINE_BURST_EN
    logic [BURST_WIDTH-1:0]     count_q, count_d;
    logic [BURST_WIDTH-1:0]     burst_len_q, burst_len_d;
    logic                       done_q, done_d;
`endif

    assign cfg_ready = (state_q != PEND);
    assign accept    = cfg_valid && cfg_ready;

    // The accumulator advances on every clock spent in RUN or PEND, including the
    // edge on which a stop (or burst completion) returns the FSM to IDLE.
    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        incr_d          = incr_q;
        offset_d        = offset_q;
        shadow_incr_d   = shadow_incr_q;
        shadow_offset_d = shadow_offset_q;
        dout_valid_d    = (state_q != IDLE);
        wrap_d          = 1'b0;
        run_end         = 1'b0;
        sum             = {1'b0, phase_q} + {1'b0, incr_q};
`ifdef SINE_BURST_EN
        count_d         = count_q;
        burst_len_d     = burst_len_q;
        done_d          = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    incr_d   = cfg_incr;
                    offset_d = cfg_offset;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    phase_d = '0;
`ifdef SINE_BURST_EN
                    count_d     = '0;
                    burst_len_d = burst_len;
`endif
                end
            end
            RUN, PEND: begin
                phase_d = sum[PHASE_WIDTH-1:0];
                wrap_d  = sum[PHASE_WIDTH];
                run_end = stop;
`ifdef SINE_BURST_EN
                if (sum[PHASE_WIDTH]) begin
                    count_d = count_q + 1'b1;
                    if (burst_len_q != '0 && count_d == burst_len_q) begin
                        run_end = 1'b1;
                        done_d  = 1'b1;
                    end
                end
`endif
                // A pending word is committed only at a wrap so the waveform never glitches mid-period.
                if (state_q == PEND) begin
                    if (run_end || sum[PHASE_WIDTH]) begin
                        incr_d   = shadow_incr_q;
                        offset_d = shadow_offset_q;
                        state_d  = RUN;
                    end
                end else if (accept) begin
                    if (run_end) begin
                        incr_d   = cfg_incr;
                        offset_d = cfg_offset;
                    end else begin
                        shadow_incr_d   = cfg_incr;
                        shadow_offset_d = cfg_offset;
                        state_d         = PEND;
                    end
                end
                if (run_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            incr_q          <= RESET_INCR;
            offset_q        <= RESET_OFFSET;
            shadow_incr_q   <= RESET_INCR;
            shadow_offset_q <= RESET_OFFSET;
            dout_valid_q    <= 1'b0;
            wrap_q          <= 1'b0;
`ifdef SINE_BURST_EN
            count_q         <= '0;
            burst_len_q     <= '0;
            done_q          <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            incr_q          <= incr_d;
            offset_q        <= offset_d;
            shadow_incr_q   <= shadow_incr_d;
            shadow_offset_q <= shadow_offset_d;
            dout_valid_q    <= dout_valid_d;
            wrap_q          <= wrap_d;
`ifdef SINE_BURST_EN
            count_q         <= count_d;
            burst_len_q     <= burst_len_d;
            done_q          <= done_d;
`endif
        end
    end

    assign addr1      = phase_q[PHASE_WIDTH-1 -: ADDRESS_WIDTH];
    assign addr2      = addr1 + offset_q;
    assign dout_valid = dout_valid_q;
    assign wrap       = wrap_q;
    assign busy       = (state_q != IDLE);
`ifdef SINE_BURST_EN
    assign done       = done_q;
`endif

endmodule
